// File: rtl/router_pkg.sv
// Shared definitions for the 1x3 router: header field positions, address
// width, destination count and the ingress FSM state encoding.
package router_pkg;

    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 2;
    localparam int ADDR_W      = 2;
    localparam int N_DEST      = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_EMPTY,
        LFD,
        HDR_WR,
        LOAD_DATA,
        CHECK,
        DROP
    } state_t;

endpackage

// File: rtl/pkt_ingress.sv
// Write-side front end of the router. Decodes the destination from the packet
// header, steers the header, payload and parity bytes into one packet FIFO,
// back-pressures the source with busy and flags parity/length errors.
module pkt_ingress #(
    parameter int N_DEST = router_pkg::N_DEST,
    parameter int DW     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pkt_valid,
    input  logic [DW-1:0]     i_data_in,
    input  logic [N_DEST-1:0] i_fifo_full,
    input  logic [N_DEST-1:0] i_fifo_empty,
    input  logic [N_DEST-1:0] i_sft_rst,
    output logic              o_busy,
    output logic [N_DEST-1:0] o_wr_en,
    output logic              o_lfd_state,
    output logic [DW-1:0]     o_fifo_din,
    output logic              o_err,
    output logic              o_drop
);

    import router_pkg::*;

    localparam int CNT_W = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    state_t              r_state;
    logic [DW-1:0]       r_hdr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DW-1:0]       r_par;
    logic [DW-1:0]       r_rx_par;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_lfd;
    logic                r_err;
    logic                r_drop;

    logic [N_DEST-1:0]   w_sel;
    logic [N_DEST-1:0]   w_hdr_sel;
    logic                w_hdr_ok;
    logic                w_hdr_empty;
    logic                w_full;
    logic                w_empty;
    logic                w_abort;

    // One-hot decode of the latched address and of the address in the byte on the bus
    always_comb begin
        w_sel     = '0;
        w_hdr_sel = '0;
        for (int i = 0; i < N_DEST; i++) begin
            if (r_addr == ADDR_W'(i)) begin
                w_sel[i] = 1'b1;
            end
            if (i_data_in[ADDR_W-1:0] == ADDR_W'(i)) begin
                w_hdr_sel[i] = 1'b1;
            end
        end
    end

    assign w_hdr_ok    = |w_hdr_sel;
    assign w_hdr_empty = |(i_fifo_empty & w_hdr_sel);
    assign w_full      = |(i_fifo_full & w_sel);
    assign w_empty     = |(i_fifo_empty & w_sel);
    assign w_abort     = (|(i_sft_rst & w_sel)) && (r_state != IDLE) && (r_state != DROP);

    // FIFO-side strobes and source back-pressure decoded from the current state
    always_comb begin
        o_busy     = 1'b0;
        o_wr_en    = '0;
        o_fifo_din = '0;
        case (r_state)
            WAIT_EMPTY, LFD, CHECK: begin
                o_busy = 1'b1;
            end
            HDR_WR: begin
                o_busy     = 1'b1;
                o_fifo_din = r_hdr;
                if (!w_abort) begin
                    o_wr_en = w_sel;
                end
            end
            LOAD_DATA: begin
                o_busy     = w_full;
                o_fifo_din = i_data_in;
                if (!w_full && !w_abort) begin
                    o_wr_en = w_sel;
                end
            end
            default: begin
            end
        endcase
    end

    // Packet FSM with header capture, running parity/length check and registered flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_hdr    <= '0;
            r_addr   <= '0;
            r_par    <= '0;
            r_rx_par <= '0;
            r_cnt    <= '0;
            r_lfd    <= 1'b0;
            r_err    <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_lfd  <= 1'b0;
            r_drop <= 1'b0;
            if (w_abort) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (i_pkt_valid) begin
                            r_hdr  <= i_data_in;
                            r_addr <= i_data_in[ADDR_W-1:0];
                            r_par  <= i_data_in;
                            r_cnt  <= '0;
                            r_err  <= 1'b0;
                            if (!w_hdr_ok) begin
                                r_state <= DROP;
                            end else if (w_hdr_empty) begin
                                r_state <= LFD;
                                r_lfd   <= 1'b1;
                            end else begin
                                r_state <= WAIT_EMPTY;
                            end
                        end
                    end
                    WAIT_EMPTY: begin
                        if (w_empty) begin
                            r_state <= LFD;
                            r_lfd   <= 1'b1;
                        end
                    end
                    LFD: begin
                        r_state <= HDR_WR;
                    end
                    HDR_WR: begin
                        r_state <= LOAD_DATA;
                    end
                    LOAD_DATA: begin
                        if (!w_full) begin
                            if (i_pkt_valid) begin
                                r_par <= r_par ^ i_data_in;
                                if (r_cnt != '1) begin
                                    r_cnt <= r_cnt + CNT_W'(1);
                                end
                            end else begin
                                r_rx_par <= i_data_in;
                                r_state  <= CHECK;
                            end
                        end
                    end
                    CHECK: begin
                        r_err   <= (r_rx_par != r_par) || (r_cnt != r_hdr[HDR_LEN_MSB:HDR_LEN_LSB]);
                        r_state <= IDLE;
                    end
                    DROP: begin
                        if (!i_pkt_valid) begin
                            r_drop  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_lfd_state = r_lfd;
    assign o_err       = r_err;
    assign o_drop      = r_drop;

endmodule

// File: tb/tb_pkt_ingress.sv
// Directed bench for pkt_ingress: each scenario is a per-cycle table of
// source/FIFO inputs and hand-computed outputs checked at the falling edge.
module tb_pkt_ingress;

    logic       clk;
    logic       rst;
    logic       i_pkt_valid;
    logic [7:0] i_data_in;
    logic [2:0] i_fifo_full;
    logic [2:0] i_fifo_empty;
    logic [2:0] i_sft_rst;
    logic       o_busy;
    logic [2:0] o_wr_en;
    logic       o_lfd_state;
    logic [7:0] o_fifo_din;
    logic       o_err;
    logic       o_drop;

    int total = 0;
    int bad   = 0;
    logic [7:0] wrLog[$];

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [2:0] full;
        logic [2:0] empty;
        logic [2:0] sft;
        logic       busy;
        logic [2:0] wr;
        logic       lfd;
        logic [7:0] din;
        logic       err;
        logic       drop;
    } vec_t;

    pkt_ingress dut (
        .clk          (clk),
        .rst          (rst),
        .i_pkt_valid  (i_pkt_valid),
        .i_data_in    (i_data_in),
        .i_fifo_full  (i_fifo_full),
        .i_fifo_empty (i_fifo_empty),
        .i_sft_rst    (i_sft_rst),
        .o_busy       (o_busy),
        .o_wr_en      (o_wr_en),
        .o_lfd_state  (o_lfd_state),
        .o_fifo_din   (o_fifo_din),
        .o_err        (o_err),
        .o_drop       (o_drop)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Log every byte the DUT writes into any FIFO
    always @(negedge clk) begin
        if (|o_wr_en) begin
            wrLog.push_back(o_fifo_din);
        end
    end

    // Hard stop if the run ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t row(input logic v, input logic [7:0] d, input logic [2:0] full,
                                 input logic [2:0] empty, input logic [2:0] sft, input logic busy,
                                 input logic [2:0] wr, input logic lfd, input logic [7:0] din,
                                 input logic err, input logic drop);
        vec_t r;
        r.v = v; r.d = d; r.full = full; r.empty = empty; r.sft = sft;
        r.busy = busy; r.wr = wr; r.lfd = lfd; r.din = din; r.err = err; r.drop = drop;
        return r;
    endfunction

    // Drive one cycle of inputs just after the rising edge and return at the falling edge
    task automatic applyStimulus(input vec_t r);
        @(posedge clk);
        #1;
        i_pkt_valid  = r.v;
        i_data_in    = r.d;
        i_fifo_full  = r.full;
        i_fifo_empty = r.empty;
        i_sft_rst    = r.sft;
        @(negedge clk);
    endtask

    task automatic test_reset();
        vec_t t[$];
        t.push_back(row(1'b1, 8'h0D, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h0D, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        rst = 1'b0;
        foreach (t[k]) begin
            applyStimulus(t[k]);
            total++;
            if ({o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop} !==
                {t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop}) begin
                bad++;
                $display("[TB] FAIL reset row %0d: got busy=%b wr=%b lfd=%b din=%h err=%b drop=%b, want busy=%b wr=%b lfd=%b din=%h err=%b drop=%b",
                         k, o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop,
                         t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop);
            end
        end
        rst = 1'b1;
        i_pkt_valid = 1'b0;
        applyStimulus(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        total++;
        if ({o_busy, o_wr_en, o_lfd_state, o_err, o_drop} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_idle: got busy=%b wr=%b lfd=%b err=%b drop=%b, want all 0",
                     o_busy, o_wr_en, o_lfd_state, o_err, o_drop);
        end
    endtask

    // Header 0x0D (len 3, addr 1), payload 11 22 33, parity byte par
    task automatic test_packet(input string name, input logic [7:0] par, input logic expErr);
        vec_t t[$];
        t.push_back(row(1'b1, 8'h0D, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h11, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h11, 3'b000, 3'b111, 3'b000, 1'b1, 3'b010, 1'b0, 8'h0D, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h11, 3'b000, 3'b111, 3'b000, 1'b0, 3'b010, 1'b0, 8'h11, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h22, 3'b000, 3'b111, 3'b000, 1'b0, 3'b010, 1'b0, 8'h22, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h33, 3'b000, 3'b111, 3'b000, 1'b0, 3'b010, 1'b0, 8'h33, 1'b0, 1'b0));
        t.push_back(row(1'b0, par,   3'b000, 3'b111, 3'b000, 1'b0, 3'b010, 1'b0, par,   1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, expErr, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, expErr, 1'b0));
        foreach (t[k]) begin
            applyStimulus(t[k]);
            total++;
            if ({o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop} !==
                {t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop}) begin
                bad++;
                $display("[TB] FAIL %s row %0d: got busy=%b wr=%b lfd=%b din=%h err=%b drop=%b, want busy=%b wr=%b lfd=%b din=%h err=%b drop=%b",
                         name, k, o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop,
                         t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop);
            end
        end
    endtask

    // Same good packet, FIFO 1 goes full for three cycles on the 0x22 byte;
    // err from the previous bad packet must clear once this header is taken
    task automatic test_fifo_full();
        vec_t t[$];
        int n22;
        t.push_back(row(1'b1, 8'h0D, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1, 1'b0));
        t.push_back(row(1'b1, 8'h11, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h11, 3'b000, 3'b111, 3'b000, 1'b1, 3'b010, 1'b0, 8'h0D, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h11, 3'b000, 3'b111, 3'b000, 1'b0, 3'b010, 1'b0, 8'h11, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h22, 3'b010, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'h22, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h22, 3'b010, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'h22, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h22, 3'b010, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'h22, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h22, 3'b000, 3'b111, 3'b000, 1'b0, 3'b010, 1'b0, 8'h22, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h33, 3'b000, 3'b111, 3'b000, 1'b0, 3'b010, 1'b0, 8'h33, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h0D, 3'b000, 3'b111, 3'b000, 1'b0, 3'b010, 1'b0, 8'h0D, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        wrLog.delete();
        foreach (t[k]) begin
            applyStimulus(t[k]);
            total++;
            if ({o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop} !==
                {t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop}) begin
                bad++;
                $display("[TB] FAIL fifo_full row %0d: got busy=%b wr=%b lfd=%b din=%h err=%b drop=%b, want busy=%b wr=%b lfd=%b din=%h err=%b drop=%b",
                         k, o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop,
                         t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop);
            end
        end
        n22 = 0;
        foreach (wrLog[k]) begin
            if (wrLog[k] == 8'h22) n22++;
        end
        total++;
        if (wrLog.size() != 5) begin
            bad++;
            $display("[TB] FAIL fifo_full_writes: got %0d FIFO writes, want 5", wrLog.size());
        end
        total++;
        if (n22 != 1) begin
            bad++;
            $display("[TB] FAIL fifo_full_once: byte 0x22 written %0d times, want 1", n22);
        end
    endtask

    // Header 0x06 (len 1, addr 2) while FIFO 2 is not yet empty; payload AA, parity AC
    task automatic test_wait_empty();
        vec_t t[$];
        t.push_back(row(1'b1, 8'h06, 3'b000, 3'b011, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'hAA, 3'b000, 3'b011, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'hAA, 3'b000, 3'b011, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'hAA, 3'b000, 3'b011, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'hAA, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'hAA, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'hAA, 3'b000, 3'b111, 3'b000, 1'b1, 3'b100, 1'b0, 8'h06, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'hAA, 3'b000, 3'b111, 3'b000, 1'b0, 3'b100, 1'b0, 8'hAA, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'hAC, 3'b000, 3'b111, 3'b000, 1'b0, 3'b100, 1'b0, 8'hAC, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        foreach (t[k]) begin
            applyStimulus(t[k]);
            total++;
            if ({o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop} !==
                {t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop}) begin
                bad++;
                $display("[TB] FAIL wait_empty row %0d: got busy=%b wr=%b lfd=%b din=%h err=%b drop=%b, want busy=%b wr=%b lfd=%b din=%h err=%b drop=%b",
                         k, o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop,
                         t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop);
            end
        end
    endtask

    // Header 0x0B (addr 3 is invalid, len 2), payload 55 66, parity 38
    task automatic test_drop();
        vec_t t[$];
        t.push_back(row(1'b1, 8'h0B, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h55, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h66, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h38, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b1));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        wrLog.delete();
        foreach (t[k]) begin
            applyStimulus(t[k]);
            total++;
            if ({o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop} !==
                {t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop}) begin
                bad++;
                $display("[TB] FAIL drop row %0d: got busy=%b wr=%b lfd=%b din=%h err=%b drop=%b, want busy=%b wr=%b lfd=%b din=%h err=%b drop=%b",
                         k, o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop,
                         t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop);
            end
        end
        total++;
        if (wrLog.size() != 0) begin
            bad++;
            $display("[TB] FAIL drop_writes: got %0d FIFO writes, want 0", wrLog.size());
        end
    endtask

    // Packet 04/77/73 to addr 0 (stray sft_rst[2] ignored), header 0x09 to addr 1
    // held during CHECK then aborted by sft_rst[1], then a len-0 packet to addr 0
    task automatic test_back_to_back();
        vec_t t[$];
        t.push_back(row(1'b1, 8'h04, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h77, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h77, 3'b000, 3'b111, 3'b000, 1'b1, 3'b001, 1'b0, 8'h04, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h77, 3'b000, 3'b111, 3'b100, 1'b0, 3'b001, 1'b0, 8'h77, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h73, 3'b000, 3'b111, 3'b000, 1'b0, 3'b001, 1'b0, 8'h73, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h09, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h09, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h01, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h01, 3'b000, 3'b111, 3'b000, 1'b1, 3'b010, 1'b0, 8'h09, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h01, 3'b000, 3'b111, 3'b000, 1'b0, 3'b010, 1'b0, 8'h01, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h02, 3'b000, 3'b111, 3'b010, 1'b0, 3'b000, 1'b0, 8'h02, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b1, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b1, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b1, 3'b001, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b001, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        t.push_back(row(1'b0, 8'h00, 3'b000, 3'b111, 3'b000, 1'b0, 3'b000, 1'b0, 8'h00, 1'b0, 1'b0));
        foreach (t[k]) begin
            applyStimulus(t[k]);
            total++;
            if ({o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop} !==
                {t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop}) begin
                bad++;
                $display("[TB] FAIL back_to_back row %0d: got busy=%b wr=%b lfd=%b din=%h err=%b drop=%b, want busy=%b wr=%b lfd=%b din=%h err=%b drop=%b",
                         k, o_busy, o_wr_en, o_lfd_state, o_fifo_din, o_err, o_drop,
                         t[k].busy, t[k].wr, t[k].lfd, t[k].din, t[k].err, t[k].drop);
            end
        end
    endtask

    // Scenario sequence
    initial begin
        rst          = 1'b0;
        i_pkt_valid  = 1'b0;
        i_data_in    = 8'h00;
        i_fifo_full  = 3'b000;
        i_fifo_empty = 3'b111;
        i_sft_rst    = 3'b000;
        test_reset();
        test_packet("good_pkt", 8'h0D, 1'b0);
        test_packet("bad_parity", 8'h0C, 1'b1);
        test_fifo_full();
        test_wait_empty();
        test_drop();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
